// File: rtl/sev_seg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display path.
// Segment vectors are ordered g..a and are active-low throughout.
package sev_seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic {
      PH_VISIBLE = 1'b0,
      PH_HIDDEN  = 1'b1
   } blink_phase_e;

   // Index width that stays legal for a range of one.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Clock-enable divider: one-cycle tick every TICK_DIV enabled cycles.
// The count freezes while enable_i is low so a paused scan resumes mid-slot.
module seg_tick_gen #(
   parameter int unsigned TICK_DIV = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable_i,
   output logic tick_o
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      cnt_d  = cnt_q;
      tick_o = 1'b0;
      if (enable_i) begin
         if (cnt_q == TERM) begin
            cnt_d  = '0;
            tick_o = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/sev_seg_scanner.sv
// Multiplexed seven-segment driver with double-buffered display data committed at
// frame boundaries, leading-zero blanking, per-digit decimal points and blink.
module sev_seg_scanner
   import sev_seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 8,
   parameter int unsigned TICK_DIV     = 100000,
   parameter int unsigned BLINK_FRAMES = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] data_i,
   input  logic [NUM_DIGITS-1:0]   dp_i,
   input  logic [NUM_DIGITS-1:0]   blink_mask_i,
   input  logic                    load_i,
   input  logic                    blank_lz_i,
   input  logic                    enable_i,
   output logic [6:0]              LED_out,
   output logic                    dp_o,
   output logic [NUM_DIGITS-1:0]   LED_ctrl,
   output logic                    load_ack_o,
   output logic                    frame_o
);

   localparam int unsigned IW = idx_width(NUM_DIGITS);
   localparam int unsigned BW = idx_width(BLINK_FRAMES);
   localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
   localparam logic [BW-1:0] LAST_BLINK = BW'(BLINK_FRAMES - 1);

   logic                    tick, wrap;
   logic [IW-1:0]           idx_q, idx_d;
   logic [BW-1:0]           blink_cnt_q;
   blink_phase_e            phase_q;
   logic [4*NUM_DIGITS-1:0] pend_data_q, shadow_data_q;
   logic [NUM_DIGITS-1:0]   pend_dp_q, pend_blink_q, shadow_dp_q, shadow_blink_q;
   logic                    pend_q;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d, ack_q, frame_q;
   logic [NUM_DIGITS-1:0]   ctrl_q, ctrl_d;
   logic [3:0]              cur_nib;
   logic                    cur_lz;

   seg_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk      (clk),
      .rst      (rst),
      .enable_i (enable_i),
      .tick_o   (tick)
   );

   assign wrap  = tick && (idx_q == LAST_IDX);
   assign idx_d = wrap ? '0 : (tick ? idx_q + IW'(1) : idx_q);

   // A digit is a leading zero when it and every digit above it are zero.
   always_comb begin
      cur_nib = shadow_data_q[{idx_q, 2'b00} +: 4];
      cur_lz  = blank_lz_i && (idx_q != '0) && ((shadow_data_q >> {idx_q, 2'b00}) == '0);
      ctrl_d  = '1;
      seg_d   = SEG_BLANK;
      dp_d    = 1'b1;
      if (enable_i) begin
         ctrl_d = ~(NUM_DIGITS'(1) << idx_q);
         seg_d  = cur_lz ? SEG_BLANK : hex_to_seg(cur_nib);
         dp_d   = ~shadow_dp_q[idx_q];
         if (phase_q == PH_HIDDEN && shadow_blink_q[idx_q]) begin
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
         end
      end
   end

   // NOTE: the display buffers are cleared on reset so a fresh display never shows stale data.
   always_ff @(posedge clk) begin
      if (!rst) begin
         idx_q          <= '0;
         blink_cnt_q    <= '0;
         phase_q        <= PH_VISIBLE;
         pend_data_q    <= '0;
         pend_dp_q      <= '0;
         pend_blink_q   <= '0;
         pend_q         <= 1'b0;
         shadow_data_q  <= '0;
         shadow_dp_q    <= '0;
         shadow_blink_q <= '0;
         seg_q          <= SEG_BLANK;
         dp_q           <= 1'b1;
         ctrl_q         <= '1;
         ack_q          <= 1'b0;
         frame_q        <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         ctrl_q  <= ctrl_d;
         ack_q   <= wrap && pend_q;
         frame_q <= wrap;
         if (wrap) begin
            if (blink_cnt_q == LAST_BLINK) begin
               blink_cnt_q <= '0;
               phase_q     <= (phase_q == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
            end else begin
               blink_cnt_q <= blink_cnt_q + BW'(1);
            end
         end
         if (wrap && pend_q) begin
            shadow_data_q  <= pend_data_q;
            shadow_dp_q    <= pend_dp_q;
            shadow_blink_q <= pend_blink_q;
         end
         // A load in the commit cycle becomes the next pending set.
         if (load_i) begin
            pend_data_q  <= data_i;
            pend_dp_q    <= dp_i;
            pend_blink_q <= blink_mask_i;
            pend_q       <= 1'b1;
         end else if (wrap) begin
            pend_q <= 1'b0;
         end
      end
   end

   assign LED_out    = seg_q;
   assign dp_o       = dp_q;
   assign LED_ctrl   = ctrl_q;
   assign load_ack_o = ack_q;
   assign frame_o    = frame_q;

endmodule
